// File: rtl/reaction_timer_ctrl_pkg.sv
// rtl/reaction_timer_ctrl_pkg.sv - shared state codes and constants for the reaction timer
package reaction_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_A = 3'd0,  // idle
    ST_B = 3'd1,  // arm
    ST_C = 3'd2,  // pre-go delay
    ST_D = 3'd3,  // timing
    ST_E = 3'd4,  // result
    ST_F = 3'd5   // fault: false start or overflow
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  BCD_MAX   = 4'd9;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// rtl/reaction_timer_ctrl_if.sv - button-side inputs and display-side outputs of the reaction timer
interface reaction_timer_ctrl_if;
  logic       start;
  logic       stop;
  logic [2:0] state;
  logic [3:0] ones;
  logic [3:0] tenths;
  logic [3:0] hundreths;
  logic [3:0] thousandths;
  logic       led_go;

  modport master (
    output start, stop,
    input  state, ones, tenths, hundreths, thousandths, led_go
  );

  modport slave (
    input  start, stop,
    output state, ones, tenths, hundreths, thousandths, led_go
  );
endinterface

// File: rtl/reaction_timer_ctrl_bcd_ms_counter.sv
// rtl/reaction_timer_ctrl_bcd_ms_counter.sv - 4-digit cascaded BCD millisecond counter, saturating at 9999
module bcd_ms_counter
  import reaction_timer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_ones,
  output logic [3:0] o_tenths,
  output logic [3:0] o_hundreths,
  output logic [3:0] o_thousandths,
  output logic       o_full
);

  logic [3:0] r_ones, r_tenths, r_hundreths, r_thousandths;
  logic       w_full;

  assign w_full = (r_ones == BCD_MAX) && (r_tenths == BCD_MAX) &&
                  (r_hundreths == BCD_MAX) && (r_thousandths == BCD_MAX);

  // Saturates at 9999 even if enabled, so the display never wraps to 0000
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ones        <= 4'd0;
      r_tenths      <= 4'd0;
      r_hundreths   <= 4'd0;
      r_thousandths <= 4'd0;
    end else if (i_en && !w_full) begin
      if (r_thousandths == BCD_MAX) begin
        r_thousandths <= 4'd0;
        if (r_hundreths == BCD_MAX) begin
          r_hundreths <= 4'd0;
          if (r_tenths == BCD_MAX) begin
            r_tenths <= 4'd0;
            r_ones   <= r_ones + 4'd1;
          end else begin
            r_tenths <= r_tenths + 4'd1;
          end
        end else begin
          r_hundreths <= r_hundreths + 4'd1;
        end
      end else begin
        r_thousandths <= r_thousandths + 4'd1;
      end
    end
  end

  assign o_ones        = r_ones;
  assign o_tenths      = r_tenths;
  assign o_hundreths   = r_hundreths;
  assign o_thousandths = r_thousandths;
  assign o_full        = w_full;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction-timer FSM with ms prescaler, LFSR pre-go delay and BCD result
module reaction_timer_ctrl
  import reaction_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV        = 50000,
  parameter int DELAY_MIN_MS    = 1000,
  parameter int DELAY_RAND_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  reaction_timer_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = 13;
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << DELAY_RAND_BITS) - 32'd1);

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_lfsr;
  logic [DW-1:0]   r_delay;
  logic            r_led_go;

  logic            w_tick;
  logic            w_go;
  logic            w_full;
  logic            w_cnt_en;
  logic            w_cnt_clr;
  logic [DW-1:0]   w_delay_load;

  assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
  assign w_go         = (r_state == ST_C) && !bus.stop && w_tick && (r_delay == DW'(1));
  assign w_delay_load = DW'(DELAY_MIN_MS) + DW'(r_lfsr & RAND_MASK);
  assign w_cnt_clr    = (r_state == ST_B);
  // A stop on a tick cycle wins, so the frozen result excludes that tick
  assign w_cnt_en     = (r_state == ST_D) && w_tick && !bus.stop;

  always_ff @(posedge clk) begin
    if (reset || w_tick || w_go) r_presc <= '0;
    else                         r_presc <= r_presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_A;
      r_delay  <= '0;
      r_led_go <= 1'b0;
    end else begin
      case (r_state)
        ST_A: if (bus.start) r_state <= ST_B;
        ST_B: begin
          r_delay <= w_delay_load;
          r_state <= ST_C;
        end
        ST_C: begin
          if (bus.stop) begin
            r_state <= ST_F;
          end else if (w_tick) begin
            if (r_delay == DW'(1)) begin
              r_state  <= ST_D;
              r_led_go <= 1'b1;
            end else begin
              r_delay <= r_delay - DW'(1);
            end
          end
        end
        ST_D: begin
          if (bus.stop) begin
            r_state  <= ST_E;
            r_led_go <= 1'b0;
          end else if (w_tick && w_full) begin
            r_state  <= ST_F;
            r_led_go <= 1'b0;
          end
        end
        ST_E, ST_F: if (bus.start) r_state <= ST_B;
        default: begin
          r_state  <= ST_A;
          r_led_go <= 1'b0;
        end
      endcase
    end
  end

  bcd_ms_counter u_bcd (
    .clk           (clk),
    .reset         (reset),
    .i_clr         (w_cnt_clr),
    .i_en          (w_cnt_en),
    .o_ones        (bus.ones),
    .o_tenths      (bus.tenths),
    .o_hundreths   (bus.hundreths),
    .o_thousandths (bus.thousandths),
    .o_full        (w_full)
  );

  assign bus.state  = r_state;
  assign bus.led_go = r_led_go;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - directed vector and sequence bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic [2:0]  st;
    logic        led;
    logic [15:0] dig;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[19];

  reaction_timer_ctrl_if bus();

  reaction_timer_ctrl #(
    .TICK_DIV        (4),
    .DELAY_MIN_MS    (3),
    .DELAY_RAND_BITS (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] dig;
  assign dig = {bus.ones, bus.tenths, bus.hundreths, bus.thousandths};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] es, input logic el, input logic [15:0] ed);
    total++;
    if (bus.state !== es || bus.led_go !== el || dig !== ed) begin
      bad++;
      $display("FAIL %s: got state=%0d led=%0b dig=%h, want state=%0d led=%0b dig=%h",
               name, bus.state, bus.led_go, dig, es, el, ed);
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int maxc);
    int n = 0;
    while (bus.state !== s && n < maxc) begin
      step();
      n++;
    end
    total++;
    if (bus.state !== s) begin
      bad++;
      $display("FAIL %s: got state=%0d after %0d cycles, want state=%0d", name, bus.state, n, s);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // reset x3, start, then C lasts 10 cycles (first tick partial), D at cycle 12, first ms after 4 D cycles
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0000};
    for (int i = 4; i <= 13; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 16'h0000};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0000};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0000};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0001};

    for (int i = 0; i < 19; i++) begin
      reset     = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.stop  = vecs[i].stop;
      step();
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].led, vecs[i].dig);
    end

    // D cycle index is now 4; stop at index 4936 after 1234 ticks
    for (int i = 0; i < 4932; i++) step();
    chk("d_1234", 3'd3, 1'b1, 16'h1234);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("stop_to_e", 3'd4, 1'b0, 16'h1234);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("e_hold", 3'd4, 1'b0, 16'h1234);
    end

    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("restart_b", 3'd1, 1'b0, 16'h1234);
    step();
    chk("restart_c", 3'd2, 1'b0, 16'h0000);
    wait_state("reach_d_1", 3'd3, 200);
    for (int i = 0; i < 200; i++) step();
    chk("d_50", 3'd3, 1'b1, 16'h0050);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_reset", 3'd0, 1'b0, 16'h0000);
    step();
    chk("post_reset_idle", 3'd0, 1'b0, 16'h0000);

    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("fs_b", 3'd1, 1'b0, 16'h0000);
    step();
    chk("fs_c", 3'd2, 1'b0, 16'h0000);
    step(); step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("false_start", 3'd5, 1'b0, 16'h0000);
    step();
    chk("fault_hold", 3'd5, 1'b0, 16'h0000);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("fault_restart_b", 3'd1, 1'b0, 16'h0000);
    step();
    chk("fault_restart_c", 3'd2, 1'b0, 16'h0000);

    // index 167 is the tick that would make 0042
    wait_state("reach_d_2", 3'd3, 200);
    for (int i = 0; i < 167; i++) step();
    chk("pre_0041", 3'd3, 1'b1, 16'h0041);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("stop_on_tick", 3'd4, 1'b0, 16'h0041);
    bus.start = 1'b1; bus.stop = 1'b1; step(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_e", 3'd1, 1'b0, 16'h0041);
    step();
    chk("ss_c", 3'd2, 1'b0, 16'h0000);

    wait_state("reach_d_3", 3'd3, 200);
    for (int i = 1; i <= 40000; i++) begin
      step();
      if (i == 396)   chk("c_0099", 3'd3, 1'b1, 16'h0099);
      if (i == 400)   chk("c_0100", 3'd3, 1'b1, 16'h0100);
      if (i == 3996)  chk("c_0999", 3'd3, 1'b1, 16'h0999);
      if (i == 4000)  chk("c_1000", 3'd3, 1'b1, 16'h1000);
      if (i == 39996) chk("c_9999", 3'd3, 1'b1, 16'h9999);
      if (i == 39999) chk("c_9999_last", 3'd3, 1'b1, 16'h9999);
    end
    chk("overflow", 3'd5, 1'b0, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("overflow_hold", 3'd5, 1'b0, 16'h9999);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Reaction-timer controller that produces the state code and the four BCD digits (ones, tenths, hundreths, thousandths) consumed by the seven-segment BCD display decoder.
- Runs a randomized pre-go delay, then counts milliseconds in BCD until the user presses stop.
- Flags false starts and overflow.
- Sits between the debounced button logic and the display decoder.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock).
DELAY_MIN_MS, 1000, fixed part of pre-go delay in ms; range 1..4095.
DELAY_RAND_BITS, 11, LFSR bits added to delay; range 0..11. 0 makes delay deterministic.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse from debouncer; begin/restart a trial
stop  in  1  single-cycle pulse from debouncer; user reaction
state  out  3  trial state code, encoding below
ones  out  4  BCD seconds digit
tenths  out  4  BCD 0.1 s digit
hundreths  out  4  BCD 0.01 s digit
thousandths  out  4  BCD 0.001 s digit
led_go  out  1  "react now" lamp

Behaviour:
- One clock; reset is synchronous, active-high, on ports clk/reset.
- Reset values: state=A(0), all digits 0, led_go=0, prescaler 0, delay counter 0, LFSR=16'hACE1.
- State encoding:
  - A=0 IDLE
  - B=1 ARM
  - C=2 DELAY
  - D=3 TIMING
  - E=4 RESULT
  - F=5 FAULT
  - Codes 6/7 are unreachable; if entered, go to A next cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every non-reset cycle.
- Prescaler: counts 0..TICK_DIV-1, wraps; tick=1 for the one cycle where count==TICK_DIV-1.
  - Forced to 0 on the C->D transition, so the first ms in D is full-length.
- Transitions, all registered, one cycle each:
  - A: start -> B.
  - B: for one cycle, clear digits and load delay_cnt = DELAY_MIN_MS + LFSR[DELAY_RAND_BITS-1:0]; then -> C. A stop in B is ignored.
  - C: delay_cnt decrements on tick.
    - stop -> F (false start; digits stay 0).
    - On a tick with delay_cnt==1 -> D, with led_go=1 from the first D cycle.
    - stop has priority over expiry in the same cycle.
  - D: on tick, increment 4-digit BCD. Thousandths carries into hundreths, tenths, then ones, all in the same cycle.
    - stop -> E; digits freeze. Stop on a tick cycle wins: no increment on that cycle.
    - Tick with digits==9,9,9,9 -> F; digits hold 9999, no wrap.
  - E, F: hold digits. start -> B.
  - start in C or D is ignored.
- led_go = 1 only while state==D.
- Digits change only in B (clear) and D (increment); otherwise stable.
- BCD digits never leave 0..9.
- start and stop together in A/E/F: start acts.
- Reset mid-trial: next cycle equals reset values regardless of state.
- Latency:
  - start -> state B: 1 cycle.
  - stop -> E/F: 1 cycle.
  - Digits valid the same cycle state enters E.

Decomposition:
- Shared package/include:
  - state codes ST_A..ST_F (3-bit)
  - LFSR seed 16'hACE1 and tap mask
  - BCD_MAX = 4'd9
- One sub-module, bcd_ms_counter:
  - Contents: the 4-digit cascaded BCD incrementer with sync clear, enable (tick & in D), and an all-nines output.
  - Outputs: digits and full flag.
  - Instantiated once.
- Prescaler, LFSR, delay counter and FSM live in reaction_timer_ctrl.

Test Plan:
Sim params for all scenarios: TICK_DIV=4, DELAY_RAND_BITS=0, DELAY_MIN_MS=3.
1. Reset asserted 3 cycles -> state=0, digits 0,0,0,0, led_go=0. Same result with reset pulsed while in D after 50 ticks.
2. start pulse -> state 1 next cycle, then 2, then 3 after exactly 3 ticks. led_go=1 in the first D cycle.
3. In D, stop after 1234 ticks -> state=4, digits ones=1, tenths=2, hundreths=3, thousandths=4. Digits stable for 100 further cycles.
4. stop issued during C -> state=5, digits 0,0,0,0, led_go=0. A following start -> 1 then 2.
5. No stop for 10000 ticks in D -> at 9999 the next tick gives state=5, digits 9,9,9,9 with no wrap to 0000. Also covers carry 0,0,9,9 -> 0,1,0,0 and 0,9,9,9 -> 1,0,0,0 mid-run.
6. stop asserted on a tick cycle in D at count 0,0,4,1 -> E holding 0,0,4,1. Separately, start+stop together in E -> state 1.
